// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared states, default command bytes and status-byte layout for the logic analyser sequencer
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_TRANSMIT = 3'd3,
    ST_STATUS   = 3'd4
  } state_t;

  localparam logic [7:0] CMD_ARM_DEF    = 8'h41;
  localparam logic [7:0] CMD_ABORT_DEF  = 8'h58;
  localparam logic [7:0] CMD_STATUS_DEF = 8'h53;

  localparam int STAT_TIMEOUT_BIT = 6;
  localparam int STAT_COUNT_LSB   = 0;
  localparam int STAT_COUNT_W     = 4;

  function automatic logic [7:0] status_byte(input logic timed_out,
                                             input logic [STAT_COUNT_W-1:0] count);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_TIMEOUT_BIT] = timed_out;
    b[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return b;
  endfunction

endpackage

// File: rtl/la_seq_timer.sv
// rtl/la_seq_timer.sv - loadable down-counter; expired marks the last counted cycle
module la_seq_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  // Flagging at 1 lets the owner leave on the same edge that would reach 0.
  assign expired = (count == W'(1));

endmodule

// File: rtl/la_sequencer.sv
// rtl/la_sequencer.sv - logic analyser run controller; LA_SEQ_TIMEOUT_EN builds the trigger timeout
module la_sequencer
  import la_pkg::*;
#(
  parameter int unsigned          TIMEOUT_W    = 24,
  parameter logic [TIMEOUT_W-1:0] TRIG_TIMEOUT = 24'd12_000_000,
  parameter logic [7:0]           CMD_ARM      = CMD_ARM_DEF,
  parameter logic [7:0]           CMD_ABORT    = CMD_ABORT_DEF,
  parameter logic [7:0]           CMD_STATUS   = CMD_STATUS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       trig,
  output logic       grant_cap,
  input  logic       done_cap,
  output logic       grant_txd,
  input  logic       done_txd,
  input  logic [7:0] txd_data,
  input  logic       txd_valid,
  output logic       txd_ack,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_data_ack,
  output logic       busy,
  output logic       timeout
);

  if (TRIG_TIMEOUT < TIMEOUT_W'(2)) begin : g_bad_timeout
    $error("TRIG_TIMEOUT must be 2 or more");
  end

  state_t     state, state_nxt;
  logic [3:0] capture_count;
  logic       expired;
  logic       abort_cmd;

  assign abort_cmd = rx_data_valid && (rx_data == CMD_ABORT);

`ifdef LA_SEQ_TIMEOUT_EN
  logic arm_load;
  logic timeout_q;

  assign arm_load = (state == ST_IDLE) && rx_data_valid && (rx_data == CMD_ARM);

  la_seq_timer #(.W(TIMEOUT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (arm_load),
    .load_value (TRIG_TIMEOUT),
    .en         (state == ST_ARMED),
    .expired    (expired)
  );

  // Abort and trigger both outrank expiry, so only a clean expiry sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (arm_load) begin
      timeout_q <= 1'b0;
    end else if (state == ST_ARMED && expired && !abort_cmd && !trig) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      capture_count <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_TRANSMIT && done_txd) begin
        capture_count <= capture_count + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_cap     = 1'b0;
    grant_txd     = 1'b0;
    txd_ack       = 1'b0;
    tx_data       = 8'h00;
    tx_data_valid = 1'b0;
    busy          = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (rx_data_valid && rx_data == CMD_ARM) begin
          state_nxt = ST_ARMED;
        end else if (rx_data_valid && rx_data == CMD_STATUS) begin
          state_nxt = ST_STATUS;
        end
      end
      ST_ARMED: begin
        if (abort_cmd) begin
          state_nxt = ST_IDLE;
        end else if (trig) begin
          state_nxt = ST_CAPTURE;
        end else if (expired) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        grant_cap = 1'b1;
        if (done_cap) begin
          state_nxt = ST_TRANSMIT;
        end
      end
      ST_TRANSMIT: begin
        grant_txd     = 1'b1;
        tx_data       = txd_data;
        tx_data_valid = txd_valid;
        txd_ack       = tx_data_ack;
        if (done_txd) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_STATUS: begin
        tx_data       = status_byte(timeout, capture_count);
        tx_data_valid = 1'b1;
        if (tx_data_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_la_sequencer.sv
// tb/tb_la_sequencer.sv - scoreboard bench for la_sequencer; expectations follow LA_SEQ_TIMEOUT_EN
module tb_la_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       trig;
  logic       grant_cap;
  logic       done_cap;
  logic       grant_txd;
  logic       done_txd;
  logic [7:0] txd_data;
  logic       txd_valid;
  logic       txd_ack;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ack;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int cap_cycles = 0;
  logic overlap = 1'b0;
  logic [7:0] sb[$];

  la_sequencer #(.TRIG_TIMEOUT(24'd10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .trig          (trig),
    .grant_cap     (grant_cap),
    .done_cap      (done_cap),
    .grant_txd     (grant_txd),
    .done_txd      (done_txd),
    .txd_data      (txd_data),
    .txd_valid     (txd_valid),
    .txd_ack       (txd_ack),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ack   (tx_data_ack),
    .busy          (busy),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (grant_cap && grant_txd) overlap = 1'b1;
      if (grant_cap) cap_cycles++;
      if (grant_txd) check("txd_ack_pass", {31'd0, txd_ack}, {31'd0, tx_data_ack});
      if (tx_data_valid && tx_data_ack) begin
        if (sb.size() == 0) check("sb_unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic stream_byte(input logic [7:0] b);
    sb.push_back(b);
    txd_data = b;
    txd_valid = 1'b1;
    tx_data_ack = 1'b0;
    tick();
    check("stall_valid", {31'd0, tx_data_valid}, 32'd1);
    check("stall_data", {24'd0, tx_data}, {24'd0, b});
    tx_data_ack = 1'b1;
    tick();
    txd_valid = 1'b0;
    tx_data_ack = 1'b0;
  endtask

  task automatic req_status(input logic [7:0] exp);
    send_byte(8'h53);
    sb.push_back(exp);
    check("status_valid", {31'd0, tx_data_valid}, 32'd1);
    check("status_data", {24'd0, tx_data}, {24'd0, exp});
    tick();
    tick();
    check("status_hold", {23'd0, tx_data_valid, tx_data}, {23'd1, exp});
    tx_data_ack = 1'b1;
    tick();
    tx_data_ack = 1'b0;
    check("status_done_busy", {31'd0, busy}, 32'd0);
    check("status_done_valid", {31'd0, tx_data_valid}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    trig = 1'b0;
    done_cap = 1'b0;
    done_txd = 1'b0;
    txd_data = 8'h00;
    txd_valid = 1'b0;
    tx_data_ack = 1'b0;
    #12;
    check("rst_outputs", {25'd0, grant_cap, grant_txd, busy, timeout, tx_data_valid, txd_ack, 1'b0},
          32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Ignored inputs in IDLE
    send_byte(8'h00);
    check("idle_byte00", {31'd0, busy}, 32'd0);
    done_cap = 1'b1;
    tick();
    done_cap = 1'b0;
    check("idle_done_cap", {29'd0, busy, grant_cap, grant_txd}, 32'd0);

    // Timeout behaviour, first so capture_count is still 0
    send_byte(8'h41);
    check("arm_busy", {31'd0, busy}, 32'd1);
    n = 0;
`ifdef LA_SEQ_TIMEOUT_EN
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 32'd10);
    check("timeout_flag", {31'd0, timeout}, 32'd1);
    req_status(8'h40);
    send_byte(8'h41);
    check("rearm_clears_timeout", {31'd0, timeout}, 32'd0);
    send_byte(8'h58);
    check("abort_idle", {31'd0, busy}, 32'd0);
`else
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("no_timeout_wait", n, 32'd30);
    check("no_timeout_flag", {31'd0, timeout}, 32'd0);
    send_byte(8'h58);
    check("abort_idle", {31'd0, busy}, 32'd0);
    req_status(8'h00);
`endif

    // Full run
    send_byte(8'h41);
    check("armed_no_grant", {30'd0, grant_cap, grant_txd}, 32'd0);
    cap_cycles = 0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("trig_grant", {30'd0, grant_cap, grant_txd}, 32'd2);
    repeat (17) tick();
    send_byte(8'h58);
    check("cap_ignores_abort", {30'd0, grant_cap, busy}, 32'd3);
    done_txd = 1'b1;
    tick();
    done_txd = 1'b0;
    check("cap_ignores_done_txd", {30'd0, grant_cap, grant_txd}, 32'd2);
    done_cap = 1'b1;
    tick();
    done_cap = 1'b0;
    check("handover", {30'd0, grant_cap, grant_txd}, 32'd1);
    check("cap_window", cap_cycles, 32'd20);
    stream_byte(8'hA5);
    stream_byte(8'h3C);
    stream_byte(8'hF0);
    done_txd = 1'b1;
    tick();
    done_txd = 1'b0;
    check("txd_release", {29'd0, grant_cap, grant_txd, busy}, 32'd0);
    req_status(8'h01);

    // Abort coinciding with trigger
    send_byte(8'h41);
    rx_data = 8'h58;
    rx_data_valid = 1'b1;
    trig = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    trig = 1'b0;
    check("race_idle", {30'd0, busy, grant_cap}, 32'd0);
    tick();
    check("race_no_grant", {31'd0, grant_cap}, 32'd0);

    // Asynchronous reset during TRANSMIT
    send_byte(8'h41);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    done_cap = 1'b1;
    tick();
    done_cap = 1'b0;
    check("pre_reset_txd", {31'd0, grant_txd}, 32'd1);
    #2;
    rst_n = 1'b0;
    txd_data = 8'hAA;
    txd_valid = 1'b1;
    tx_data_ack = 1'b1;
    #1;
    check("async_rst_ctrl", {26'd0, grant_cap, grant_txd, busy, timeout, tx_data_valid, txd_ack},
          32'd0);
    check("async_rst_data", {24'd0, tx_data}, 32'd0);
    txd_valid = 1'b0;
    tx_data_ack = 1'b0;
    txd_data = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    req_status(8'h00);

    check("sb_drained", sb.size(), 32'd0);
    check("grant_overlap", {31'd0, overlap}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
